// File: rtl/ef_sram_fifo_pkg.sv
// Shared constants and types for the EF SRAM FWFT FIFO controller.
// Optional level/threshold outputs are enabled with EF_SRAM_FIFO_LEVEL_EN.
package ef_sram_fifo_pkg;
  localparam int unsigned AW            = 10;
  localparam int unsigned DW            = 32;
  localparam int unsigned DEPTH         = 1 << AW;
  localparam int unsigned OBUF_DEPTH    = 2;
  localparam int unsigned LVL_W         = AW + 2;
  localparam int unsigned AFULL_MARGIN  = 4;
  localparam int unsigned AEMPTY_MARGIN = 4;

  typedef enum logic [1:0] {
    AccIdle,
    AccWrite,
    AccRead
  } acc_e;
endpackage

// File: rtl/ef_sram_fifo_obuf.sv
// Two-entry prefetch buffer in front of the FIFO output; head register drives out_data
// directly so it holds its last value once the buffer drains.
module ef_sram_fifo_obuf #(
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cap_i,
  input  logic [DW-1:0] cap_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic [1:0]    cnt_o
);
  import ef_sram_fifo_pkg::*;

  localparam logic [1:0] CntFull = OBUF_DEPTH[1:0];

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pop;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    pop    = pop_i && (cnt_q != 2'd0);
    unique case ({cap_i, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = cap_data_i;
        else               tail_d = cap_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == CntFull) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Count is unchanged; the captured word lands behind whatever survives the pop.
        if (cnt_q == CntFull) begin
          head_d = tail_q;
          tail_d = cap_data_i;
        end else begin
          head_d = cap_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = (cnt_q != 2'd0);
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/ef_sram_fifo_ctrl.sv
// First-word-fall-through FIFO over a single-port EF SRAM tile, arbitrating writes and
// prefetch reads on the one port. Define EF_SRAM_FIFO_LEVEL_EN for level/threshold outputs.
module ef_sram_fifo_ctrl #(
  parameter int unsigned AW = ef_sram_fifo_pkg::AW,
  parameter int unsigned DW = ef_sram_fifo_pkg::DW
) (
  input  logic          UserCLK,
  input  logic          RST,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef EF_SRAM_FIFO_LEVEL_EN
  output logic [AW+1:0] level,
  output logic          almost_full,
  output logic          almost_empty,
`endif
  output logic [DW-1:0] DI,
  output logic [DW-1:0] BEN,
  output logic [AW-1:0] AD,
  output logic          EN,
  output logic          R_WB,
  input  logic [DW-1:0] DO
);
  import ef_sram_fifo_pkg::*;

  localparam logic [AW:0] DepthCnt  = {1'b1, {AW{1'b0}}};
  localparam logic [2:0]  ObufDepth = OBUF_DEPTH[2:0];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   sram_cnt_q, sram_cnt_d;
  logic          inflight_q;
  logic [1:0]    buf_cnt;
  logic          sram_empty, sram_full, starving, space;
  logic          wr_issue, rd_issue;
  acc_e          acc;

  always_comb begin
    sram_empty = (sram_cnt_q == '0);
    sram_full  = (sram_cnt_q == DepthCnt);
    starving   = (buf_cnt == 2'd0) && !inflight_q;
    space      = ({1'b0, buf_cnt} + {2'b00, inflight_q}) < ObufDepth;
    // Stall pushes while the output is starving so the pending read gets the port.
    in_ready   = !RST && !sram_full && !(!sram_empty && starving);
    wr_issue   = in_valid && in_ready;
    rd_issue   = !sram_empty && space && (starving || !in_valid);

    if (wr_issue)      acc = AccWrite;
    else if (rd_issue) acc = AccRead;
    else               acc = AccIdle;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sram_cnt_d = sram_cnt_q;
    EN         = 1'b0;
    R_WB       = 1'b1;
    AD         = '0;
    DI         = '0;
    BEN        = '0;
    unique case (acc)
      AccWrite: begin
        EN         = 1'b1;
        R_WB       = 1'b0;
        AD         = wr_ptr_q;
        DI         = in_data;
        BEN        = '1;
        wr_ptr_d   = wr_ptr_q + 1'b1;
        sram_cnt_d = sram_cnt_q + 1'b1;
      end
      AccRead: begin
        EN         = 1'b1;
        AD         = rd_ptr_q;
        rd_ptr_d   = rd_ptr_q + 1'b1;
        sram_cnt_d = sram_cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= rd_issue;
    end
  end

  ef_sram_fifo_obuf #(
    .DW(DW)
  ) u_obuf (
    .clk_i      (UserCLK),
    .rst_i      (RST),
    .cap_i      (inflight_q),
    .cap_data_i (DO),
    .pop_i      (out_ready),
    .data_o     (out_data),
    .valid_o    (out_valid),
    .cnt_o      (buf_cnt)
  );

`ifdef EF_SRAM_FIFO_LEVEL_EN
  localparam logic [AW+1:0] DepthLvl  = {2'b01, {AW{1'b0}}};
  localparam logic [AW+1:0] AfullLvl  = DepthLvl - AFULL_MARGIN[AW+1:0];
  localparam logic [AW+1:0] AemptyLvl = AEMPTY_MARGIN[AW+1:0];

  assign level        = {1'b0, sram_cnt_q} + {{(AW+1){1'b0}}, inflight_q}
                        + {{AW{1'b0}}, buf_cnt};
  assign almost_full  = (level >= AfullLvl);
  assign almost_empty = (level <= AemptyLvl);
`endif
endmodule

// File: tb/tb_ef_sram_fifo_ctrl.sv
// Self-checking bench for ef_sram_fifo_ctrl with a behavioural 1024x32 SRAM tile and a
// scoreboard queue; level checks are compiled in with EF_SRAM_FIFO_LEVEL_EN.
module tb_ef_sram_fifo_ctrl;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] di, ben, dout;
  logic [AW-1:0] ad;
  logic          en, r_wb;
`ifdef EF_SRAM_FIFO_LEVEL_EN
  logic [AW+1:0] level;
  logic          almost_full, almost_empty;
`endif

  always #5 clk = ~clk;

  ef_sram_fifo_ctrl #(
    .AW(AW),
    .DW(DW)
  ) dut (
    .UserCLK      (clk),
    .RST          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
`ifdef EF_SRAM_FIFO_LEVEL_EN
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .DI           (di),
    .BEN          (ben),
    .AD           (ad),
    .EN           (en),
    .R_WB         (r_wb),
    .DO           (dout)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (en) begin
      if (r_wb) dout <= mem[ad];
      else      mem[ad] <= (mem[ad] & ~ben) | (di & ben);
    end
  end

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] sb [$];
  logic [AW-1:0] exp_wr, exp_rd;
  logic [DW-1:0] last_pop;

  task automatic settle(input logic v, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  // Bookkeeping after a sampled cycle: record accepted pushes, pointer advances and pops.
  task automatic track();
    if (in_valid && in_ready) begin
      sb.push_back(in_data);
      exp_wr = exp_wr + 1'b1;
    end
    if (en && r_wb) exp_rd = exp_rd + 1'b1;
    if (out_valid && out_ready && sb.size() != 0) begin
      last_pop = sb[0];
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stream: out_valid=%b out_data=%h in_ready=%b, want 0 0 0",
               out_valid, out_data, in_ready);
    end
    n_cmp++;
    if ({en, r_wb} !== 2'b01 || ad !== '0 || di !== '0 || ben !== '0) begin
      n_err++;
      $display("FAIL reset_sram: en=%b r_wb=%b ad=%h di=%h ben=%h, want 0 1 0 0 0",
               en, r_wb, ad, di, ben);
    end
`ifdef EF_SRAM_FIFO_LEVEL_EN
    n_cmp++;
    if (level !== '0 || almost_full !== 1'b0 || almost_empty !== 1'b1) begin
      n_err++;
      $display("FAIL reset_level: level=%0d af=%b ae=%b, want 0 0 1",
               level, almost_full, almost_empty);
    end
`endif
    rst = 1'b0; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
    end
    sb.delete(); exp_wr = '0; exp_rd = '0; last_pop = '0;
  endtask

  task automatic test_latency();
    settle(1'b1, 32'hA5A5_0001, 1'b0);
    n_cmp++;
    if ({in_ready, en, r_wb, ad, ben, di} !== {1'b1, 1'b1, 1'b0, 10'd0, 32'hFFFF_FFFF,
                                              32'hA5A5_0001}) begin
      n_err++;
      $display("FAIL lat_write: rdy=%b en=%b r_wb=%b ad=%h ben=%h di=%h, want 1 1 0 0 ffffffff a5a50001",
               in_ready, en, r_wb, ad, ben, di);
    end
    track();
    settle(1'b0, '0, 1'b0);
    n_cmp++;
    if ({en, r_wb, ad, ben, di, out_valid} !== {1'b1, 1'b1, 10'd0, 32'd0, 32'd0, 1'b0}) begin
      n_err++;
      $display("FAIL lat_read: en=%b r_wb=%b ad=%h ben=%h di=%h ov=%b, want 1 1 0 0 0 0",
               en, r_wb, ad, ben, di, out_valid);
    end
    track();
    settle(1'b0, '0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || en !== 1'b0) begin
      n_err++;
      $display("FAIL lat_e1: out_valid=%b en=%b, want 0 0", out_valid, en);
    end
    track();
    settle(1'b0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001) begin
      n_err++;
      $display("FAIL lat_e2: out_valid=%b out_data=%h, want 1 a5a50001", out_valid, out_data);
    end
    track();
    settle(1'b0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL lat_after_pop: out_valid=%b, want 0", out_valid);
    end
    track();
  endtask

  task automatic test_fill_drain();
    int acc = 0;
    int cyc = 0;
    while (acc < 1026 && cyc < 4000) begin
      settle(cyc[0], 32'hF000_0000 | acc, 1'b0);
      if (in_valid && in_ready) acc++;
      track();
      cyc++;
    end
    n_cmp++;
    if (acc != 1026) begin
      n_err++;
      $display("FAIL fill_count: accepted=%0d, want 1026", acc);
    end
    for (int i = 0; i < 4; i++) begin
      settle(i[0], 32'hDEAD_BEEF, 1'b0);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL full_hold: in_ready=%b out_valid=%b, want 0 1", in_ready, out_valid);
      end
`ifdef EF_SRAM_FIFO_LEVEL_EN
      n_cmp++;
      if (level !== 12'd1026 || almost_full !== 1'b1) begin
        n_err++;
        $display("FAIL full_level: level=%0d af=%b, want 1026 1", level, almost_full);
      end
`endif
      track();
    end
    cyc = 0;
    while (sb.size() != 0 && cyc < 3000) begin
      settle(1'b0, '0, 1'b1);
      if (out_valid) begin
        n_cmp++;
        if (out_data !== sb[0]) begin
          n_err++;
          $display("FAIL drain_data: got=%h, want %h", out_data, sb[0]);
        end
      end
      track();
      cyc++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d words left, want 0", sb.size());
    end
    settle(1'b0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_empty: out_valid=%b, want 0", out_valid);
    end
    track();
  endtask

  task automatic test_random();
    int np = 0;
    int npop = 0;
    int cyc = 0;
    logic v;
    while (npop < 3000 && cyc < 30000) begin
      v = (np < 3000) && ($urandom_range(0, 9) < 7);
      settle(v, $urandom, $urandom_range(0, 9) < 6);
      n_cmp++;
      if (en && !r_wb) begin
        if (!(in_valid && in_ready) || ad !== exp_wr || ben !== '1 || di !== in_data) begin
          n_err++;
          $display("FAIL rnd_write: hs=%b ad=%h ben=%h di=%h, want 1 %h ffffffff %h",
                   in_valid && in_ready, ad, ben, di, exp_wr, in_data);
        end
      end else if (en && r_wb) begin
        if ((in_valid && in_ready) || ad !== exp_rd || ben !== '0 || di !== '0) begin
          n_err++;
          $display("FAIL rnd_read: hs=%b ad=%h ben=%h di=%h, want 0 %h 0 0",
                   in_valid && in_ready, ad, ben, di, exp_rd);
        end
      end else if (in_valid && in_ready) begin
        n_err++;
        $display("FAIL rnd_idle: push accepted with en=%b, want en=1", en);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0 || out_data !== sb[0]) begin
          n_err++;
          $display("FAIL rnd_data: got=%h, want %h", out_data, sb.size() ? sb[0] : 32'hx);
        end
        npop++;
      end
      if (in_valid && in_ready) np++;
      track();
      cyc++;
    end
    n_cmp++;
    if (npop != 3000 || sb.size() != 0) begin
      n_err++;
      $display("FAIL rnd_count: popped=%0d left=%0d, want 3000 0", npop, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int np = 0;
    int cyc = 0;
    logic prev_rd = 1'b0;
    while ((np < 200 || sb.size() != 0) && cyc < 2000) begin
      settle(np < 200, 32'hC0DE_0000 | np, 1'b1);
      if (en && r_wb && in_valid) begin
        n_cmp++;
        if (out_valid || prev_rd || in_ready) begin
          n_err++;
          $display("FAIL b2b_rd_priority: ov=%b inflight=%b in_ready=%b, want 0 0 0",
                   out_valid, prev_rd, in_ready);
        end
      end
      if (out_valid) begin
        n_cmp++;
        if (sb.size() == 0 || out_data !== sb[0]) begin
          n_err++;
          $display("FAIL b2b_data: got=%h, want %h", out_data, sb.size() ? sb[0] : 32'hx);
        end
      end
      if (in_valid && in_ready) np++;
      prev_rd = en && r_wb;
      track();
      cyc++;
    end
    n_cmp++;
    if (np != 200 || sb.size() != 0) begin
      n_err++;
      $display("FAIL b2b_count: pushed=%0d left=%0d, want 200 0", np, sb.size());
    end
  endtask

  task automatic test_reset_midop();
    int acc = 0;
    int cyc = 0;
    logic found = 1'b0;
    while (acc < 6 && cyc < 100) begin
      settle(cyc[0], 32'h1111_0000 | acc, 1'b0);
      if (in_valid && in_ready) acc++;
      track();
      cyc++;
    end
    settle(1'b0, '0, 1'b1);
    track();
    cyc = 0;
    while (!found && cyc < 50) begin
      settle(1'b0, '0, 1'b0);
      if (en && r_wb && out_valid) found = 1'b1;
      else track();
      cyc++;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL midrst_setup: no read with buffered data, want one");
    end
    @(posedge clk);
    #2; rst = 1'b1; in_valid = 1'b1; #1;
    n_cmp++;
    if (out_valid !== 1'b0 || en !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_force: ov=%b en=%b in_ready=%b, want 0 0 0",
               out_valid, en, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    sb.delete(); exp_wr = '0; exp_rd = '0;
    settle(1'b1, 32'h5EED_0001, 1'b0);
    track();
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 10) begin
      settle(1'b0, '0, 1'b1);
      if (out_valid) found = 1'b1;
      track();
      cyc++;
    end
    n_cmp++;
    if (!found || last_pop !== 32'h5EED_0001) begin
      n_err++;
      $display("FAIL midrst_first: seen=%b data=%h, want 1 5eed0001", found, last_pop);
    end
  endtask

  task automatic test_pop_empty();
    for (int i = 0; i < 4; i++) begin
      settle(1'b0, '0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0 || en !== 1'b0 || out_data !== 32'h5EED_0001) begin
        n_err++;
        $display("FAIL pop_empty: ov=%b en=%b out_data=%h, want 0 0 5eed0001",
                 out_valid, en, out_data);
      end
`ifdef EF_SRAM_FIFO_LEVEL_EN
      n_cmp++;
      if (level !== '0 || almost_empty !== 1'b1) begin
        n_err++;
        $display("FAIL pop_empty_level: level=%0d ae=%b, want 0 1", level, almost_empty);
      end
`endif
      track();
    end
    settle(1'b1, 32'h0BAD_F00D, 1'b0);
    track();
    for (int i = 0; i < 6; i++) begin
      settle(1'b0, '0, 1'b1);
      if (out_valid) begin
        n_cmp++;
        if (out_data !== 32'h0BAD_F00D) begin
          n_err++;
          $display("FAIL pop_empty_next: got=%h, want 0badf00d", out_data);
        end
      end
      track();
    end
    n_cmp++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pop_empty_drain: left=%0d ov=%b, want 0 0", sb.size(), out_valid);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_fill_drain();
    test_random();
    test_back_to_back();
    test_reset_midop();
    test_pop_empty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
